// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the time-multiplexed audio mixer.
// State encoding, accumulator sizing and offset-binary conversion.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUT
  } state_e;

  function automatic int acc_width(
    input int out_w,
    input int gain_w,
    input int num_ch
  );
    return out_w + gain_w + $clog2(num_ch) + 1;
  endfunction

  function automatic logic [63:0] offs_to_signed(
    input logic [63:0] v,
    input int          w
  );
    return v ^ (64'd1 << (w - 1));
  endfunction

  function automatic logic [63:0] signed_to_offs(
    input logic [63:0] v,
    input int          w
  );
    return v ^ (64'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/audio_mix_sat.sv
// Arithmetic shift of the mix accumulator and saturating narrow
// to the signed output range; clip_o flags a clamped sample.
module audio_mix_sat #(
  parameter int ACC_W = 28,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [OUT_W-1:0] y_o,
  output logic                    clip_o
);

  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-OUT_W:0]    hi;

  always_comb begin
    shifted = acc_i >>> SHIFT;
    hi      = shifted[ACC_W-1:OUT_W-1];
    y_o     = shifted[OUT_W-1:0];
    clip_o  = 1'b0;
    // fits only if every bit above the result sign matches it
    if (!((&hi) || (~|hi))) begin
      clip_o = 1'b1;
      if (shifted[ACC_W-1]) begin
        y_o = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        y_o = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/audio_mixer_n.sv
// N-channel mono mixer, one channel per clock through a shared multiplier.
// Optional peak meter enabled by `define AUDIO_MIXER_PEAK_EN.
module audio_mixer_n
  import audio_mix_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                IN_W        = 16,
  parameter int                OUT_W       = 16,
  parameter int                GAIN_W      = 8,
  parameter int                GAIN_FRAC   = 7,
  parameter logic [NUM_CH-1:0] CH_UNSIGNED = '1,
  parameter bit                OUT_SIGNED  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_stb_i,
  input  logic [NUM_CH*IN_W-1:0]   ch_data_i,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain_i,
  input  logic                     ovr_clr_i,
`ifdef AUDIO_MIXER_PEAK_EN
  output logic [OUT_W-2:0]         peak_o,
  input  logic                     peak_clr_i,
`endif
  output logic [OUT_W-1:0]         sample_o,
  output logic                     valid_o,
  output logic                     clip_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int ACC_W = acc_width(OUT_W, GAIN_W, NUM_CH);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SH    = OUT_W - IN_W;
  localparam logic [OUT_W-1:0] ZERO =
    OUT_SIGNED ? '0 : (OUT_W'(1) << (OUT_W - 1));

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [NUM_CH*IN_W-1:0]     data_q, data_d;
  logic [NUM_CH*GAIN_W-1:0]   gain_q, gain_d;
  logic [OUT_W-1:0]           sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       clip_q, clip_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;

  logic [IN_W-1:0]            raw;
  logic [IN_W-1:0]            s_in;
  logic [OUT_W-1:0]           s_ext;
  logic signed [GAIN_W:0]     g_s;
  logic signed [OUT_W+GAIN_W:0] prod;
  logic [OUT_W-1:0]           y_sat;
  logic                       sat_clip;
  logic [OUT_W-1:0]           y_out;

  always_comb begin
    raw   = data_q[idx_q*IN_W +: IN_W];
    s_in  = CH_UNSIGNED[idx_q] ?
            IN_W'(offs_to_signed(64'(raw), IN_W)) : raw;
    s_ext = OUT_W'(s_in) << SH;
    g_s   = $signed({1'b0, gain_q[idx_q*GAIN_W +: GAIN_W]});
    prod  = $signed(s_ext) * g_s;
  end

  audio_mix_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (GAIN_FRAC)
  ) u_sat (
    .acc_i  (acc_q),
    .y_o    (y_sat),
    .clip_o (sat_clip)
  );

  always_comb begin
    y_out = OUT_SIGNED ? y_sat :
            OUT_W'(signed_to_offs(64'(y_sat), OUT_W));
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    data_d    = data_q;
    gain_d    = gain_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    clip_d    = 1'b0;
    overrun_d = overrun_q & ~ovr_clr_i;
    unique case (state_q)
      ST_ACCUM: begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d = ST_OUT;
        end
        if (sample_stb_i) begin
          overrun_d = 1'b1;
        end
      end
      ST_OUT: begin
        sample_d = y_out;
        valid_d  = 1'b1;
        clip_d   = sat_clip;
        state_d  = ST_IDLE;
      end
      default: ;
    endcase
    // the output cycle can already take the next strobe
    if (sample_stb_i && state_q != ST_ACCUM) begin
      state_d = ST_ACCUM;
      data_d  = ch_data_i;
      gain_d  = ch_gain_i;
      acc_d   = '0;
      idx_d   = '0;
    end
    busy_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      gain_q    <= '0;
      sample_q  <= ZERO;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      gain_q    <= gain_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_o  = sample_q;
  assign valid_o   = valid_q;
  assign clip_o    = clip_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

`ifdef AUDIO_MIXER_PEAK_EN
  logic [OUT_W-2:0] peak_q, peak_d;
  logic [OUT_W-2:0] mag;
  logic [OUT_W-1:0] neg;

  always_comb begin
    neg = -y_sat;
    if (!y_sat[OUT_W-1]) begin
      mag = y_sat[OUT_W-2:0];
    end else if (y_sat == {1'b1, {(OUT_W-1){1'b0}}}) begin
      mag = '1;
    end else begin
      mag = neg[OUT_W-2:0];
    end
    peak_d = peak_q;
    if (state_q == ST_OUT) begin
      peak_d = (mag > peak_q) ? mag : peak_q;
    end else if (peak_clr_i) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`endif

endmodule
